// File: rtl/axi4_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi4_lite_pkg
// Shared definitions for the AXI4-Lite register file:
//   OKAY / SLVERR   - response codes driven on bresp / rresp
//   wr_state_t      - write-channel FSM states
//   rd_state_t      - read-channel FSM states
// ---------------------------------------------------------------------------
package axi4_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_HAVE_A = 2'd1,
        W_HAVE_D = 2'd2,
        W_RESP   = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_reg_file_rd.sv
// ---------------------------------------------------------------------------
// axi4_lite_reg_file_rd
// Read channel of the AXI4-Lite register file: AR/R FSM, address decode and
// read-data mux. Read-only registers return the matching hw_d slice.
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   araddr/arvalid/arready read address channel
//   rdata/rresp/rvalid/rready read data channel
//   reg_q                  current register contents (from the write path)
//   hw_d                   hardware values for read-only registers
// ---------------------------------------------------------------------------
module axi4_lite_reg_file_rd
    import axi4_lite_pkg::*;
#(
    parameter int               A       = 32,
    parameter int               N       = 4,
    parameter int               NREGS   = 16,
    parameter logic [NREGS-1:0] RO_MASK = '0
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [A-1:0]           araddr,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [8*N-1:0]         rdata,
    output logic [1:0]             rresp,
    output logic                   rvalid,
    input  logic                   rready,
    input  logic [NREGS*8*N-1:0]   reg_q,
    input  logic [NREGS*8*N-1:0]   hw_d
);

    localparam int           DW         = 8 * N;
    localparam int           OFF_W      = $clog2(N);
    localparam int           IDX_W      = $clog2(NREGS);
    // One extra bit so NREGS*N never wraps in the comparison.
    localparam logic [A:0]   ADDR_LIMIT = (A+1)'(NREGS * N);

    rd_state_t        r_rstate;
    logic             r_arready;
    logic             r_rvalid;
    logic [1:0]       r_rresp;
    logic [DW-1:0]    r_rdata;

    logic [IDX_W-1:0] w_idx;
    logic             w_in_range;
    logic             w_ar_hs;
    logic [DW-1:0]    w_sel;

    assign w_idx      = araddr[OFF_W +: IDX_W];
    assign w_in_range = ({1'b0, araddr} < ADDR_LIMIT);
    assign w_ar_hs    = arvalid & r_arready;
    assign w_sel      = RO_MASK[w_idx] ? hw_d[int'(w_idx)*DW +: DW]
                                       : reg_q[int'(w_idx)*DW +: DW];

    // Data is captured at the AR handshake, so a write landing on the same
    // edge is not visible to this read.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rresp   <= OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata   <= w_in_range ? w_sel : '0;
                        r_rresp   <= w_in_range ? OKAY : SLVERR;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b1;
                    r_rvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rresp   = r_rresp;
    assign rdata   = r_rdata;

endmodule

// File: rtl/axi4_lite_reg_file.sv
// ---------------------------------------------------------------------------
// axi4_lite_reg_file
// AXI4-Lite slave exposing NREGS registers of N bytes each. The write path
// (AW/W/B FSM and register storage) lives here; the read path is the
// axi4_lite_reg_file_rd sub-module. Registers flagged in RO_MASK reject
// writes with SLVERR and read back the matching hw_d slice.
// Optional feature: define AXI4_LITE_REG_FILE_STRB_EN to add the wstrb port
// and byte-granular writes; otherwise every accepted write updates all bytes.
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   awaddr/awvalid/awready        write address channel
//   wdata/[wstrb]/wvalid/wready   write data channel
//   bresp/bvalid/bready           write response channel
//   araddr/arvalid/arready        read address channel
//   rdata/rresp/rvalid/rready     read data channel
//   reg_q                         register contents, register k at slice k
//   hw_d                          hardware values for read-only registers
//   wr_pulse                      one-cycle strobe per register written
// ---------------------------------------------------------------------------
module axi4_lite_reg_file
    import axi4_lite_pkg::*;
#(
    parameter int               A       = 32,
    parameter int               N       = 4,
    parameter int               NREGS   = 16,
    parameter logic [NREGS-1:0] RO_MASK = '0
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [A-1:0]           awaddr,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [8*N-1:0]         wdata,
`ifdef AXI4_LITE_REG_FILE_STRB_EN
    input  logic [N-1:0]           wstrb,
`endif
    input  logic                   wvalid,
    output logic                   wready,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [A-1:0]           araddr,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [8*N-1:0]         rdata,
    output logic [1:0]             rresp,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [NREGS*8*N-1:0]   reg_q,
    input  logic [NREGS*8*N-1:0]   hw_d,
    output logic [NREGS-1:0]       wr_pulse
);

    localparam int           DW         = 8 * N;
    localparam int           OFF_W      = $clog2(N);
    localparam int           IDX_W      = $clog2(NREGS);
    localparam logic [A:0]   ADDR_LIMIT = (A+1)'(NREGS * N);

    function automatic logic [DW-1:0] f_byte_mask(input logic [N-1:0] strb);
        logic [DW-1:0] mask;
        for (int i = 0; i < N; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

    wr_state_t        r_wstate;
    logic             r_awready;
    logic             r_wready;
    logic [A-1:0]     r_awaddr;
    logic [DW-1:0]    r_wdata;
    logic [N-1:0]     r_wstrb;
    logic             r_bvalid;
    logic [1:0]       r_bresp;
    logic [NREGS-1:0] r_wr_pulse;
    logic [DW-1:0]    r_regs [NREGS];

    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_commit;
    logic [A-1:0]     w_addr;
    logic [DW-1:0]    w_data;
    logic [N-1:0]     w_strb_in;
    logic [N-1:0]     w_strb;
    logic [DW-1:0]    w_mask;
    logic [IDX_W-1:0] w_idx;
    logic             w_in_range;
    logic             w_ok;

`ifdef AXI4_LITE_REG_FILE_STRB_EN
    assign w_strb_in = wstrb;
`else
    assign w_strb_in = '1;
`endif

    assign w_aw_hs = awvalid & r_awready;
    assign w_w_hs  = wvalid & r_wready;

    // Second of the two channel handshakes completes the write this cycle.
    always_comb begin
        w_commit = 1'b0;
        case (r_wstate)
            W_IDLE:   w_commit = w_aw_hs & w_w_hs;
            W_HAVE_A: w_commit = w_w_hs;
            W_HAVE_D: w_commit = w_aw_hs;
            default:  w_commit = 1'b0;
        endcase
    end

    // Use the live bus for whichever channel is completing right now.
    assign w_addr     = (r_wstate == W_HAVE_A) ? r_awaddr : awaddr;
    assign w_data     = (r_wstate == W_HAVE_D) ? r_wdata  : wdata;
    assign w_strb     = (r_wstate == W_HAVE_D) ? r_wstrb  : w_strb_in;
    assign w_mask     = f_byte_mask(w_strb);
    assign w_idx      = w_addr[OFF_W +: IDX_W];
    assign w_in_range = ({1'b0, w_addr} < ADDR_LIMIT);
    assign w_ok       = w_in_range & ~RO_MASK[w_idx];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate   <= W_IDLE;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= OKAY;
            r_wr_pulse <= '0;
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_wr_pulse <= '0;
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs && !w_w_hs) begin
                        r_awaddr  <= awaddr;
                        r_awready <= 1'b0;
                        r_wstate  <= W_HAVE_A;
                    end else if (w_w_hs && !w_aw_hs) begin
                        r_wdata   <= wdata;
                        r_wstrb   <= w_strb_in;
                        r_wready  <= 1'b0;
                        r_wstate  <= W_HAVE_D;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: ;
            endcase
            // Rejected writes still get a response but touch no state.
            if (w_commit) begin
                r_wstate  <= W_RESP;
                r_awready <= 1'b0;
                r_wready  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_ok ? OKAY : SLVERR;
                if (w_ok) begin
                    r_regs[w_idx] <= (r_regs[w_idx] & ~w_mask) | (w_data & w_mask);
                    r_wr_pulse    <= {{(NREGS-1){1'b0}}, 1'b1} << w_idx;
                end
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int k = 0; k < NREGS; k++) begin
            reg_q[k*DW +: DW] = r_regs[k];
        end
    end

    assign awready  = r_awready;
    assign wready   = r_wready;
    assign bvalid   = r_bvalid;
    assign bresp    = r_bresp;
    assign wr_pulse = r_wr_pulse;

    axi4_lite_reg_file_rd #(
        .A       (A),
        .N       (N),
        .NREGS   (NREGS),
        .RO_MASK (RO_MASK)
    ) u_rd (
        .aclk    (aclk),
        .aresetn (aresetn),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .reg_q   (reg_q),
        .hw_d    (hw_d)
    );

endmodule

// File: tb/tb_axi4_lite_reg_file.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_reg_file
// Bench for axi4_lite_reg_file with register 3 read-only. Directed vector
// table, hand-written corner sequences and randomized traffic against a
// word-array reference model.
// ---------------------------------------------------------------------------
module tb_axi4_lite_reg_file;
    import axi4_lite_pkg::*;

    localparam int          A     = 32;
    localparam int          N     = 4;
    localparam int          NREGS = 16;
    localparam logic [15:0] RO    = 16'h0008;

    logic                  aclk;
    logic                  aresetn;
    logic [31:0]           awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
`ifdef AXI4_LITE_REG_FILE_STRB_EN
    logic [3:0]            wstrb;
`endif
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [31:0]           araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic [NREGS*32-1:0]   reg_q;
    logic [NREGS*32-1:0]   hw_d;
    logic [NREGS-1:0]      wr_pulse;

    axi4_lite_reg_file #(.A(A), .N(N), .NREGS(NREGS), .RO_MASK(RO)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
`ifdef AXI4_LITE_REG_FILE_STRB_EN
        .wstrb    (wstrb),
`endif
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .reg_q    (reg_q),
        .hw_d     (hw_d),
        .wr_pulse (wr_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;

    // Reference model: one word per register plus the hardware values.
    logic [31:0] m_regs [NREGS];
    logic [31:0] hw_m   [NREGS];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic bit m_in_range(input logic [31:0] addr);
        return addr < NREGS * N;
    endfunction

    function automatic logic [1:0] m_wresp(input logic [31:0] addr);
        if (!m_in_range(addr)) return SLVERR;
        if (RO[addr / N]) return SLVERR;
        return OKAY;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] addr);
        if (!m_in_range(addr)) return 32'h0;
        if (RO[addr / N]) return hw_m[addr / N];
        return m_regs[addr / N];
    endfunction

    task automatic m_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        if (m_wresp(addr) != OKAY) return;
        idx = addr / N;
        for (int b = 0; b < N; b++) begin
`ifdef AXI4_LITE_REG_FILE_STRB_EN
            if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
`else
            m_regs[idx][8*b +: 8] = data[8*b +: 8];
`endif
        end
    endtask

    task automatic chk_regq();
        for (int k = 0; k < NREGS; k++) begin
            chk($sformatf("reg_q[%0d]", k), reg_q[k*32 +: 32], m_regs[k]);
        end
    endtask

    // Drive one write. AW and W start at the given cycle offsets; B is
    // accepted after bdelay stall cycles. Returns the response and the
    // wr_pulse seen in the first response cycle.
    task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_start, input int w_start,
                          input int bdelay, output logic [1:0] resp, output logic [15:0] pulse);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs;
        bit w_hs;
        int c = 0;
        resp  = 2'b11;
        pulse = 16'hFFFF;
        awaddr = addr;
        wdata  = data;
`ifdef AXI4_LITE_REG_FILE_STRB_EN
        wstrb  = strb;
`endif
        while (!(aw_done && w_done)) begin
            if (c > 30) begin
                chk("wr_timeout", 1, 0);
                awvalid = 1'b0;
                wvalid  = 1'b0;
                return;
            end
            awvalid = !aw_done && (c >= aw_start);
            wvalid  = !w_done && (c >= w_start);
            if (aw_done) chk("awready_low_after_aw", awready, 0);
            if (w_done)  chk("wready_low_after_w", wready, 0);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
            c++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("bvalid_rise", bvalid, 1);
        resp  = bresp;
        pulse = wr_pulse;
        bready = 1'b0;
        for (int i = 0; i < bdelay; i++) begin
            @(posedge aclk); #1;
            chk("bvalid_hold", bvalid, 1);
            chk("bresp_hold", bresp, resp);
            chk("wr_pulse_single", wr_pulse, 0);
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        chk("bvalid_clear", bvalid, 0);
        chk("wr_pulse_clear", wr_pulse, 0);
    endtask

    task automatic axi_rd(input logic [31:0] addr, input int rdelay,
                          output logic [31:0] data, output logic [1:0] resp);
        bit hs;
        int c = 0;
        data = '0;
        resp = 2'b11;
        araddr  = addr;
        arvalid = 1'b1;
        while (1) begin
            if (c > 30) begin
                chk("rd_timeout", 1, 0);
                arvalid = 1'b0;
                return;
            end
            hs = arready;
            @(posedge aclk); #1;
            c++;
            if (hs) break;
        end
        arvalid = 1'b0;
        chk("rvalid_rise", rvalid, 1);
        chk("arready_busy", arready, 0);
        data = rdata;
        resp = rresp;
        for (int i = 0; i < rdelay; i++) begin
            @(posedge aclk); #1;
            chk("rvalid_hold", rvalid, 1);
            chk("rdata_hold", rdata, data);
            chk("rresp_hold", rresp, resp);
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        chk("rvalid_clear", rvalid, 0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  wresp;
        logic [15:0] pulse;
        logic [1:0]  rresp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [1:0]  resp;
        logic [15:0] pulse;
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;

        vecs[0] = '{32'h0000_0008, 32'hDEAD_BEEF, OKAY,   16'h0004, OKAY,   32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_000B, 32'hCAFE_F00D, OKAY,   16'h0004, OKAY,   32'hCAFE_F00D};
        vecs[2] = '{32'h0000_003C, 32'h1357_9BDF, OKAY,   16'h8000, OKAY,   32'h1357_9BDF};
        vecs[3] = '{32'h0000_000C, 32'hFFFF_FFFF, SLVERR, 16'h0000, OKAY,   32'hA5A5_A5A5};
        vecs[4] = '{32'h0000_0040, 32'h5555_5555, SLVERR, 16'h0000, SLVERR, 32'h0000_0000};
        vecs[5] = '{32'h0000_0000, 32'h1122_3344, OKAY,   16'h0001, OKAY,   32'h1122_3344};
        vecs[6] = '{32'h1000_0000, 32'h0000_0077, SLVERR, 16'h0000, SLVERR, 32'h0000_0000};

        aresetn = 1'b0;
        awaddr = '0; awvalid = 0; wdata = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
`ifdef AXI4_LITE_REG_FILE_STRB_EN
        wstrb = '0;
`endif
        for (int k = 0; k < NREGS; k++) begin
            hw_m[k]   = $urandom;
            m_regs[k] = '0;
        end
        hw_m[3] = 32'hA5A5_A5A5;
        for (int k = 0; k < NREGS; k++) hw_d[k*32 +: 32] = hw_m[k];

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_reg_q", |reg_q, 0);
        aresetn = 1'b1;
        chk("rel_awready", awready, 1);
        chk("rel_wready", wready, 1);
        chk("rel_arready", arready, 1);

        // Directed vectors: AW+W together, then read back.
        foreach (vecs[i]) begin
            axi_wr(vecs[i].addr, vecs[i].data, 4'hF, 0, 0, 0, resp, pulse);
            chk($sformatf("vec%0d_bresp", i), resp, vecs[i].wresp);
            chk($sformatf("vec%0d_pulse", i), pulse, vecs[i].pulse);
            m_write(vecs[i].addr, vecs[i].data, 4'hF);
            axi_rd(vecs[i].addr, 0, rd, resp);
            chk($sformatf("vec%0d_rresp", i), resp, vecs[i].rresp);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
        end
        chk_regq();

        // W first, AW three cycles later.
        axi_wr(32'h04, 32'h0000_1234, 4'hF, 3, 0, 0, resp, pulse);
        chk("wfirst_bresp", resp, OKAY);
        chk("wfirst_pulse", pulse, 16'h0002);
        chk("wfirst_reg1", reg_q[1*32 +: 32], 32'h0000_1234);
        m_write(32'h04, 32'h0000_1234, 4'hF);

        // AW first, W two cycles later.
        axi_wr(32'h18, 32'h600D_0006, 4'hF, 0, 2, 1, resp, pulse);
        chk("awfirst_bresp", resp, OKAY);
        chk("awfirst_pulse", pulse, 16'h0040);
        m_write(32'h18, 32'h600D_0006, 4'hF);

        // Out-of-range read, and a write response stalled five cycles.
        axi_rd(32'h40, 2, rd, resp);
        chk("oor_rresp", resp, SLVERR);
        chk("oor_rdata", rd, 0);
        axi_wr(32'h14, 32'hAAAA_0001, 4'hF, 0, 0, 5, resp, pulse);
        chk("bstall_bresp", resp, OKAY);
        m_write(32'h14, 32'hAAAA_0001, 4'hF);

        // Read sampled on the same edge as a write to that register.
        awaddr = 32'h14; wdata = 32'hBBBB_0002; araddr = 32'h14;
`ifdef AXI4_LITE_REG_FILE_STRB_EN
        wstrb = 4'hF;
`endif
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("race_bvalid", bvalid, 1);
        chk("race_rvalid", rvalid, 1);
        chk("race_rdata_old", rdata, 32'hAAAA_0001);
        chk("race_reg5_new", reg_q[5*32 +: 32], 32'hBBBB_0002);
        chk("race_pulse", wr_pulse, 16'h0020);
        bready = 1; rready = 1;
        @(posedge aclk); #1;
        bready = 0; rready = 0;
        chk("race_bvalid_clear", bvalid, 0);
        chk("race_rvalid_clear", rvalid, 0);
        m_write(32'h14, 32'hBBBB_0002, 4'hF);

`ifdef AXI4_LITE_REG_FILE_STRB_EN
        // Byte strobes on register 0 (holds 0x11223344 from the table).
        axi_wr(32'h00, 32'hFFFF_FFFF, 4'b0101, 0, 0, 0, resp, pulse);
        chk("strb_bresp", resp, OKAY);
        chk("strb_reg0", reg_q[0 +: 32], 32'h11FF_33FF);
        m_write(32'h00, 32'hFFFF_FFFF, 4'b0101);
        axi_wr(32'h04, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, resp, pulse);
        chk("strb0_bresp", resp, OKAY);
        chk("strb0_pulse", pulse, 16'h0002);
        chk("strb0_reg1", reg_q[32 +: 32], 32'h0000_1234);
`endif

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            logic [1:0]  exp_resp;
            logic [15:0] exp_pulse;
            addr = $urandom_range(0, 19) * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) addr = addr | 32'h0001_0000;
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            exp_resp  = m_wresp(addr);
            exp_pulse = (exp_resp == OKAY) ? (16'h0001 << (addr / N)) : 16'h0000;
            axi_wr(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), resp, pulse);
            chk($sformatf("rnd%0d_bresp", it), resp, exp_resp);
            chk($sformatf("rnd%0d_pulse", it), pulse, exp_pulse);
            m_write(addr, data, strb);
            addr = $urandom_range(0, 19) * 4 + $urandom_range(0, 3);
            axi_rd(addr, $urandom_range(0, 2), rd, resp);
            chk($sformatf("rnd%0d_rresp", it), resp, m_in_range(addr) ? OKAY : SLVERR);
            chk($sformatf("rnd%0d_rdata", it), rd, m_rdata(addr));
        end
        chk_regq();

        // Reset while the write FSM holds an address but no data.
        awaddr = 32'h10; awvalid = 1;
        @(posedge aclk); #1;
        awvalid = 0;
        chk("have_a_awready", awready, 0);
        chk("have_a_wready", wready, 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_bresp", bresp, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_pulse", wr_pulse, 0);
        chk("mid_rst_reg_q", |reg_q, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        chk("post_rst_awready", awready, 1);
        chk("post_rst_wready", wready, 1);
        chk("post_rst_arready", arready, 1);
        for (int k = 0; k < NREGS; k++) m_regs[k] = '0;

        // Fresh write after reset; the abandoned address must not leak in.
        axi_wr(32'h20, 32'h0BAD_CAFE, 4'hF, 1, 0, 0, resp, pulse);
        chk("post_rst_bresp", resp, OKAY);
        chk("post_rst_pulse", pulse, 16'h0100);
        m_write(32'h20, 32'h0BAD_CAFE, 4'hF);
        chk_regq();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi4_lite_reg_file.md
AXI4_LITE_REG_FILE -- requirements
Module: axi4_lite_reg_file

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, ports named aclk and aresetn.
REQ-002 Parameter A, 32, address width in bits.
REQ-003 Parameter N, 4, data width in bytes (data = 8*N bits), power of two >= 1.
REQ-004 Parameter NREGS, 16, number of registers, >= 2.
REQ-005 Parameter RO_MASK, 0 (NREGS bits), bit k set = register k read-only, sourced from hw_d.
REQ-006 aclk  in  1  clock.
REQ-007 aresetn  in  1  asynchronous active-low reset.
REQ-008 awaddr/awvalid in A/1, awready out 1; wdata in 8N, wvalid in 1, wready out 1; bresp out 2, bvalid out 1, bready in 1.
REQ-009 araddr/arvalid in A/1, arready out 1; rdata out 8N, rresp out 2, rvalid out 1, rready in 1.
REQ-010 reg_q  out  NREGS*8N  current register contents, register k at slice k.
REQ-011 hw_d  in  NREGS*8N  hardware values returned for read-only registers.
REQ-012 wr_pulse  out  NREGS  one-cycle strobe, bit k high the cycle register k is written.

Function
REQ-013 Index = addr[log2(N) +: clog2(NREGS)]; address >= NREGS*N SHALL be out of range; low log2(N) address bits ignored.
REQ-014 Write FSM states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP; awready high in W_IDLE/W_HAVE_D, wready high in W_IDLE/W_HAVE_A.
REQ-015 W_IDLE: AW and W same cycle -> W_RESP; AW only -> W_HAVE_A; W only -> W_HAVE_D; the missing channel's handshake -> W_RESP.
REQ-016 Register update and wr_pulse SHALL occur the cycle after both AW and W are captured; bvalid rises that same cycle.
REQ-017 bresp SHALL be OKAY (2'b00) for in-range writable registers, SLVERR (2'b10) for out-of-range or RO_MASK registers; those writes SHALL change no state and raise no wr_pulse.
REQ-018 bvalid, bresp held stable until bready; handshake returns FSM to W_IDLE; at most one outstanding write.
REQ-019 Read FSM states R_IDLE, R_DATA; arready high only in R_IDLE; AR handshake -> R_DATA, rvalid high the next cycle (latency 1).
REQ-020 rdata SHALL be the register value (hw_d slice for RO registers) sampled at the AR handshake cycle; out-of-range gives rdata 0, rresp SLVERR, else OKAY.
REQ-021 rdata/rresp/rvalid held stable until rready; handshake returns to R_IDLE; at most one outstanding read.
REQ-022 Read and write FSMs SHALL run independently; a read sampled in the update cycle of a write to the same register SHALL return the pre-write value.
REQ-023 All ready signals SHALL depend only on FSM state (no combinational path from valid to ready).

Reset
REQ-024 On aresetn low: both FSMs idle, all registers 0, reg_q 0, wr_pulse 0, bvalid/rvalid 0, bresp/rresp 0, rdata 0.
REQ-025 Reset mid-transaction SHALL abandon it without register update; after release awready/wready/arready SHALL be 1 in the first cycle.

Configuration
REQ-026 Macro AXI4_LITE_REG_FILE_STRB_EN defined: input port wstrb [N-1:0] exists; only bytes with strobe set update; wstrb = 0 to a writable register gives OKAY with wr_pulse and no data change.
REQ-027 Macro undefined: no wstrb port; every accepted write updates all N bytes.

Structure
REQ-028 axi4_lite_pkg SHALL hold resp constants OKAY/SLVERR and the write/read FSM state enums.
REQ-029 The read path SHALL be sub-module axi4_lite_reg_file_rd (R FSM, decode, rdata mux); the write path stays in the top.

Verification
REQ-030 AW 0x08 + W 0xDEADBEEF same cycle -> bvalid next cycle, bresp 00, wr_pulse[2] one cycle, reg_q slice 2 = 0xDEADBEEF.
REQ-031 W 0x1234 first, AW 0x04 three cycles later -> wready low after W, bresp 00 one cycle after AW, register 1 = 0x1234.
REQ-032 AR 0x40 with NREGS 16, N 4 -> rvalid next cycle, rresp 10, rdata 0; bready held low 5 cycles -> bvalid/bresp stable.
REQ-033 RO_MASK bit 3, hw_d slice 3 = 0xA5A5A5A5: write 0x0C -> bresp 10, no wr_pulse; read 0x0C -> 0xA5A5A5A5, rresp 00.
REQ-034 With STRB_EN, register 0 = 0x11223344, write 0xFFFFFFFF wstrb 4'b0101 -> 0x11FF33FF; aresetn pulse while in W_HAVE_A -> all outputs 0, readies 1 after release.
